dmem_arbiter: RTL and testbench

Arbitrates the single-cycle data-memory/peripheral bus between the pipeline CPU MEM stage and a DMA requester, such as a UART program loader. The CPU has default ownership with zero added latency. The DMA obtains the bus in locked, address-incrementing bursts. A starvation counter and a post-burst cooldown bound the wait on both sides. `cpu_stall` freezes the pipeline while the DMA owns the bus.

---
 rtl/dmem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-cycle data-memory/peripheral bus between the pipeline
//   CPU MEM stage and a DMA requester (for example a UART program loader).
//   The CPU owns the bus by default and gets no added latency. The DMA gets
//   the bus in locked, address-incrementing bursts. A starvation counter
//   bounds how long a pending DMA waits behind CPU traffic. A one-cycle
//   post-burst cooldown guarantees the CPU a slot between bursts.
//
// Parameters
//   DATA_W    data width
//   LEN_W     burst length field width; a burst is dma_len+1 beats
//   MAX_WAIT  max cycles a pending DMA waits behind continuous CPU traffic
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   cpu_rd/cpu_wr/cpu_addr     CPU load/store request, byte address
//   cpu_wdata, cpu_rdata       CPU store data / load data (= mem_rdata)
//   cpu_stall                  CPU access not served this cycle
//   dma_req                    level burst request, held until dma_gnt
//   dma_wr/dma_addr/dma_len    burst direction, start address and beats-1,
//                              all sampled at grant
//   dma_wdata                  current write beat data
//   dma_gnt, dma_beat          DMA owns the bus / beat performed this cycle
//   dma_rdata, dma_rvalid      registered read beat data and its valid
//   dma_done                   one-cycle pulse, cycle after the last beat
//   mem_rd/mem_wr/mem_addr     downstream strobes and address
//   mem_wdata, mem_rdata       downstream write data / combinational read data

module dmem_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,

  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [31:0]       dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_beat,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_done,

  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [WAIT_W-1:0]   wait_cnt;
  logic [LEN_W-1:0]    beats_left;
  logic [31:0]         addr_q;
  logic                wr_q;
  logic                cool;

  logic                cpu_req;
  logic                grant;
  logic                last_beat;

  assign cpu_req   = cpu_rd | cpu_wr;
  // A pending DMA wins when the CPU is quiet or has starved it long enough;
  // never in the cooldown cycle right after a burst.
  assign grant     = (state_q == IDLE) && dma_req && !cool &&
                     (!cpu_req || (wait_cnt == WAIT_MAX));
  assign last_beat = (state_q == BURST) && (beats_left == '0);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant)     state_d = BURST;
      BURST:   if (last_beat) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic: bus mux and handshake flags, combinational from state
  // ---------------------------------------------------------------------
  always_comb begin
    mem_rd    = cpu_rd;
    mem_wr    = cpu_wr;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    dma_gnt   = 1'b0;
    dma_beat  = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      BURST: begin
        mem_rd    = !wr_q;
        mem_wr    = wr_q;
        mem_addr  = addr_q;
        mem_wdata = dma_wdata;
        cpu_stall = cpu_req;
        dma_gnt   = 1'b1;
        dma_beat  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign cpu_rdata = mem_rdata;

  // ---------------------------------------------------------------------
  // Starvation counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state_q != IDLE || !dma_req || grant) begin
      wait_cnt <= '0;
    end else if (cpu_req && !cool && wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Burst bookkeeping: address, remaining beats, direction, cooldown
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      beats_left <= '0;
      wr_q       <= 1'b0;
      cool       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cool <= 1'b0;
          if (grant) begin
            addr_q     <= dma_addr;
            beats_left <= dma_len;
            wr_q       <= dma_wr;
          end
        end
        BURST: begin
          addr_q     <= addr_q + 32'd4;
          beats_left <= beats_left - 1'b1;
          cool       <= last_beat;
        end
        default: begin
          cool <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // DMA return path: registered read data, valid and done pulses
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      dma_done <= last_beat;
      if (state_q == BURST) begin
        dma_rdata  <= mem_rdata;
        dma_rvalid <= !wr_q;
      end else begin
        dma_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_wr;
  logic [31:0] dma_addr;
  logic [3:0]  dma_len;
  logic [31:0] dma_wdata, dma_rdata;
  logic        dma_gnt, dma_beat, dma_rvalid, dma_done;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Bench-side downstream memory: 1024 words, combinational read, write at edge.
  logic [31:0] mem [0:1023];
  logic        clr;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (mem_wr) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[11:2]];

  dmem_arbiter #(.DATA_W(32), .LEN_W(4), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_beat(dma_beat),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_done(dma_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; clr = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 32'h55; cpu_wdata = 0;
    dma_req = 0; dma_wr = 0; dma_addr = 0; dma_len = 0; dma_wdata = 0;

    // Reset state
    sample();
    check("rst_gnt",    dma_gnt,    0);
    check("rst_beat",   dma_beat,   0);
    check("rst_stall",  cpu_stall,  0);
    check("rst_rvalid", dma_rvalid, 0);
    check("rst_done",   dma_done,   0);
    check("rst_rdata",  dma_rdata,  0);
    check("rst_maddr",  mem_addr,   32'h55);
    step();
    clr = 1'b0; reset = 1'b1; cpu_addr = 0;
    step();

    // 1: CPU only, write then read
    cpu_wr = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    sample();
    check("t1_mem_wr",  mem_wr,   1);
    check("t1_maddr",   mem_addr, 32'h10);
    check("t1_mwdata",  mem_wdata, 32'hDEADBEEF);
    check("t1_stall_w", cpu_stall, 0);
    check("t1_gnt_w",   dma_gnt,   0);
    step();
    cpu_wr = 0; cpu_rd = 1;
    sample();
    check("t1_mem_rd",  mem_rd,    1);
    check("t1_rdata",   cpu_rdata, 32'hDEADBEEF);
    check("t1_stall_r", cpu_stall, 0);
    step();
    cpu_rd = 0;

    // 2: DMA write burst, CPU idle
    dma_req = 1; dma_wr = 1; dma_addr = 32'h100; dma_len = 3; dma_wdata = 32'hA0;
    sample();
    check("t2_gnt_pre", dma_gnt, 0);
    step();
    dma_req = 0; dma_addr = 32'hFF0; dma_len = 9; dma_wr = 0;
    for (int i = 0; i < 4; i++) begin
      dma_wdata = 32'hA0 + i;
      sample();
      check("t2_gnt",   dma_gnt,  1);
      check("t2_beat",  dma_beat, 1);
      check("t2_maddr", mem_addr, 32'h100 + 4 * i);
      check("t2_mwr",   mem_wr,   1);
      check("t2_done0", dma_done, 0);
      step();
    end
    sample();
    check("t2_done",     dma_done, 1);
    check("t2_gnt_post", dma_gnt,  0);
    check("t2_mwr_post", mem_wr,   0);
    step();
    sample();
    check("t2_done_1cy", dma_done, 0);
    check("t2_m100", mem[32'h100 >> 2], 32'hA0);
    check("t2_m104", mem[32'h104 >> 2], 32'hA1);
    check("t2_m108", mem[32'h108 >> 2], 32'hA2);
    check("t2_m10c", mem[32'h10C >> 2], 32'hA3);
    step();

    // 3: contention, continuous CPU reads
    cpu_rd = 1; cpu_addr = 32'h10;
    dma_req = 1; dma_wr = 1; dma_addr = 32'h300; dma_len = 1; dma_wdata = 32'hC0;
    for (int k = 0; k < 8; k++) begin
      sample();
      check("t3_cpu_stall", cpu_stall, 0);
      check("t3_cpu_gnt",   dma_gnt,   0);
      check("t3_cpu_maddr", mem_addr,  32'h10);
      step();
    end
    dma_req = 0;
    for (int j = 0; j < 2; j++) begin
      sample();
      check("t3_b_stall", cpu_stall, 1);
      check("t3_b_gnt",   dma_gnt,   1);
      check("t3_b_maddr", mem_addr,  32'h300 + 4 * j);
      check("t3_b_mwr",   mem_wr,    1);
      step();
    end
    sample();
    check("t3_cool_stall", cpu_stall, 0);
    check("t3_cool_gnt",   dma_gnt,   0);
    check("t3_cool_done",  dma_done,  1);
    check("t3_cool_rdata", cpu_rdata, 32'hDEADBEEF);
    step();
    cpu_rd = 0;

    // 4: back-to-back requests with a CPU store in the cooldown cycle
    dma_req = 1; dma_wr = 1; dma_addr = 32'h400; dma_len = 0; dma_wdata = 32'hD0;
    sample();
    check("t4_gnt_pre", dma_gnt, 0);
    step();
    dma_addr = 32'h500;
    sample();
    check("t4_b1_gnt",   dma_gnt,  1);
    check("t4_b1_maddr", mem_addr, 32'h400);
    step();
    cpu_wr = 1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
    sample();
    check("t4_cool_gnt",   dma_gnt,   0);
    check("t4_cool_done",  dma_done,  1);
    check("t4_cool_stall", cpu_stall, 0);
    check("t4_cool_maddr", mem_addr,  32'h20);
    check("t4_cool_mwr",   mem_wr,    1);
    step();
    cpu_wr = 0;
    sample();
    check("t4_d_gnt",  dma_gnt,  0);
    check("t4_d_done", dma_done, 0);
    step();
    dma_req = 0; dma_wdata = 32'hD1;
    sample();
    check("t4_b2_gnt",   dma_gnt,  1);
    check("t4_b2_maddr", mem_addr, 32'h500);
    step();
    sample();
    check("t4_b2_done", dma_done, 1);
    check("t4_m400", mem[32'h400 >> 2], 32'hD0);
    check("t4_m500", mem[32'h500 >> 2], 32'hD1);
    check("t4_m020", mem[32'h020 >> 2], 32'h12345678);
    step();

    // 5: read burst from preloaded words
    cpu_wr = 1; cpu_addr = 32'h200; cpu_wdata = 32'h11;
    step();
    cpu_addr = 32'h204; cpu_wdata = 32'h22;
    step();
    cpu_wr = 0;
    dma_req = 1; dma_wr = 0; dma_addr = 32'h200; dma_len = 1;
    sample();
    check("t5_gnt_pre", dma_gnt, 0);
    step();
    dma_req = 0;
    sample();
    check("t5_r1_mrd",    mem_rd,     1);
    check("t5_r1_mwr",    mem_wr,     0);
    check("t5_r1_maddr",  mem_addr,   32'h200);
    check("t5_r1_rvalid", dma_rvalid, 0);
    step();
    sample();
    check("t5_r2_rvalid", dma_rvalid, 1);
    check("t5_r2_rdata",  dma_rdata,  32'h11);
    check("t5_r2_maddr",  mem_addr,   32'h204);
    step();
    sample();
    check("t5_r3_rvalid", dma_rvalid, 1);
    check("t5_r3_rdata",  dma_rdata,  32'h22);
    check("t5_r3_done",   dma_done,   1);
    check("t5_r3_gnt",    dma_gnt,    0);
    step();
    sample();
    check("t5_r4_rvalid", dma_rvalid, 0);
    check("t5_r4_done",   dma_done,   0);
    step();

    // 6: reset asserted during the third beat of an 8-beat write burst
    dma_req = 1; dma_wr = 1; dma_addr = 32'h600; dma_len = 7; dma_wdata = 32'hB0;
    sample();
    check("t6_gnt_pre", dma_gnt, 0);
    step();
    dma_req = 0;
    sample();
    check("t6_b1_maddr", mem_addr, 32'h600);
    step();
    dma_wdata = 32'hB1;
    sample();
    check("t6_b2_maddr", mem_addr, 32'h604);
    step();
    dma_wdata = 32'hB2;
    check("t6_b3_gnt",   dma_gnt,  1);
    check("t6_b3_maddr", mem_addr, 32'h608);
    check("t6_b3_mwr",   mem_wr,   1);
    #1 reset = 1'b0;
    #1;
    check("t6_rst_gnt",  dma_gnt,  0);
    check("t6_rst_beat", dma_beat, 0);
    check("t6_rst_mwr",  mem_wr,   0);
    step();
    step();
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      sample();
      check("t6_post_done", dma_done, 0);
      check("t6_post_gnt",  dma_gnt,  0);
      check("t6_post_mwr",  mem_wr,   0);
      step();
    end
    check("t6_m600", mem[32'h600 >> 2], 32'hB0);
    check("t6_m604", mem[32'h604 >> 2], 32'hB1);
    check("t6_m608", mem[32'h608 >> 2], 32'h0);
    check("t6_m60c", mem[32'h60C >> 2], 32'h0);
    check("t6_m61c", mem[32'h61C >> 2], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
